serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
//
// PURPOSE
//  Bit-serial adder controller. Sequences two half-adder cells plus a carry flop, one bit per
//  clock, LSB first, to add two WIDTH-bit operands. Trades WIDTH cycles of latency for single-bit
//  datapath area. Sits between a host issuing start/operands and any consumer of o_sum/o_carry.
//
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2); bit counter is $clog2(WIDTH) bits
//
// PORTS
//  i_clk      in   1      system clock, rising edge
//  i_rst_n    in   1      asynchronous active-low reset
//  i_start    in   1      request: sample operands and begin addition
//  i_a        in   WIDTH  operand A (unsigned; two's complement when overflow enabled)
//  i_b        in   WIDTH  operand B
//  o_busy     out  1      high while an addition is in progress
//  o_done     out  1      one-cycle pulse: o_sum/o_carry valid
//  o_sum      out  WIDTH  result, held from o_done until next accepted start
//  o_carry    out  1      carry-out of MSB, held like o_sum
//  o_overflow out  1      signed overflow (only when SERIAL_ADDER_OVF_EN defined)
//
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; o_busy, o_done, o_sum, o_carry, o_overflow,
//    bit counter, carry flop, operand shift regs all 0.
//  - FSM states: IDLE, ADD, DONE.
//    IDLE: i_start=1 at edge -> latch i_a, i_b into shift regs, carry=0, count=0, go ADD.
//    ADD : each edge processes bit[count]: HA1 = a^b, a&b; HA2 = HA1.s^carry, HA1.s&carry;
//          sum bit shifts into result MSB (right shift); carry <= HA1.c | HA2.c; count++.
//          At count==WIDTH-1 the edge processes final bit and goes DONE.
//    DONE: o_done=1 for exactly this cycle. i_start=1 -> accept new operands, go ADD (back-to-back);
//          else -> IDLE.
//  - Latency: start sampled at edge 0; bits processed at edges 1..WIDTH; o_done high in the cycle
//    after edge WIDTH. Throughput: one addition per WIDTH+1 cycles.
//  - o_busy = 1 in ADD, 0 in IDLE and DONE.
//  - o_sum/o_carry update only at the DONE transition (internal shift reg separate); stable otherwise.
//  - i_start during ADD: ignored, operands not resampled, no error flag.
//  - i_a/i_b only sampled at start acceptance; changes afterwards have no effect.
//  - Reset mid-operation: addition aborted, all outputs cleared, no o_done pulse.
//  - Result arithmetic: {o_carry,o_sum} == i_a + i_b exactly (WIDTH+1 bits); wraps modulo 2^WIDTH.
//
// CONFIGURATION
//  SERIAL_ADDER_OVF_EN defined: o_overflow port present; at DONE set to
//    (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), i.e. carry into MSB XOR carry out; held like o_sum.
//  Not defined: o_overflow port and its logic absent; all else identical.
//
// TESTING (WIDTH=8)
//  1. Reset, i_start with A=0x5A,B=0x3C -> o_busy 8 cycles, o_done pulse 1 cycle, o_sum=0x96, o_carry=0.
//  2. A=0xFF,B=0x01 -> o_sum=0x00, o_carry=1; A=0x00,B=0x00 -> o_sum=0x00, o_carry=0.
//  3. i_start re-asserted with A=0x11,B=0x22 at cycle 3 of ADD -> ignored; first result 0x96 unchanged.
//  4. i_start held high in DONE with A=0x01,B=0x02 -> no IDLE cycle; next o_done exactly 9 cycles
//     after previous, o_sum=0x03.
//  5. i_rst_n low at cycle 4 of ADD -> outputs 0 immediately, no o_done; next start adds correctly.
//  6. OVF_EN: A=0x7F,B=0x01 -> o_sum=0x80, o_overflow=1; A=0xFF,B=0xFF -> o_sum=0xFE, o_carry=1,
//     o_overflow=0. Plus 1000 random pairs vs. reference a+b.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, two half-adder cells plus a carry flop, one bit per clock, LSB first
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_start    sample i_a/i_b and begin an addition (accepted in IDLE and DONE)
//   i_a, i_b   WIDTH-bit operands
//   o_busy     high while bits are being processed
//   o_done     one-cycle pulse, o_sum/o_carry valid
//   o_sum      WIDTH-bit result, held until the next completed addition
//   o_carry    carry out of the MSB, held like o_sum
//   o_overflow signed overflow, present only when SERIAL_ADDER_OVF_EN is defined
//
// Configuration macro: SERIAL_ADDER_OVF_EN enables the o_overflow port and its logic.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             o_overflow
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ha1_s, ha1_c, ha2_s, ha2_c, carry_nx;
    logic [WIDTH-1:0] acc_ext;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign ha1_s    = a_q[0] ^ b_q[0];
    assign ha1_c    = a_q[0] & b_q[0];
    assign ha2_s    = ha1_s ^ carry_q;
    assign ha2_c    = ha1_s & carry_q;
    assign carry_nx = ha1_c | ha2_c;
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign acc_ext  = {ha2_s, acc_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ADD: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                acc_d   = acc_ext[WIDTH-1:1];
                carry_d = carry_nx;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = acc_ext;
                    cout_d  = carry_nx;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry into the MSB cell XOR carry out of it
                    ovf_d   = carry_q ^ carry_nx;
`endif
                end
            end
            default: begin
                state_d = i_start ? ADD : IDLE;
                if (i_start) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign o_busy  = (state_q == ADD);
    assign o_done  = (state_q == DONE);
    assign o_sum   = sum_q;
    assign o_carry = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of serial_adder_ctrl against a cycle-count model
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b1;
    logic         i_start = 1'b0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         o_busy, o_done, o_carry;
    logic [W-1:0] o_sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         o_overflow;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_sum     (o_sum),
        .o_carry   (o_carry)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .o_overflow(o_overflow)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sovf(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    endfunction

    // Model: phase 0 = waiting, 1..W = cycles spent adding, W+1 = result cycle.
    int           m_phase = 0;
    logic [W-1:0] m_sum = '0, p_sum = '0;
    logic         m_cout = 1'b0, p_cout = 1'b0, m_ovf = 1'b0, p_ovf = 1'b0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_phase <= 0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (m_phase == 0 || m_phase == W + 1) begin
            m_phase <= i_start ? 1 : 0;
            if (i_start) begin
                {p_cout, p_sum} <= {1'b0, i_a} + {1'b0, i_b};
                p_ovf           <= sovf(i_a, i_b);
            end
        end else if (m_phase == W) begin
            m_phase <= W + 1;
            m_sum   <= p_sum;
            m_cout  <= p_cout;
            m_ovf   <= p_ovf;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    always @(negedge i_clk) begin
        chk("busy", 32'(o_busy), 32'(m_phase >= 1 && m_phase <= W));
        chk("done", 32'(o_done), 32'(m_phase == W + 1));
        chk("sum", 32'(o_sum), 32'(m_sum));
        chk("carry", 32'(o_carry), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
`endif
    end

    // Called at a negedge; returns at the negedge where o_done is seen.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, output int cyc, output int busy_n);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
        @(negedge i_clk);
        i_start = 1'b0;
        cyc     = 1;
        busy_n  = 0;
        while (!o_done && cyc < 30) begin
            busy_n += int'(o_busy);
            @(negedge i_clk);
            cyc++;
        end
        chk("done_seen", 32'(o_done), 32'd1);
    endtask

    initial begin
        int cyc, bn;
        logic [W-1:0] ra, rb;
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_sum", 32'(o_sum), 32'd0);
        chk("rst_carry", 32'(o_carry), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        do_add(8'h5A, 8'h3C, cyc, bn);
        chk("t1_latency", 32'(cyc), 32'(W + 1));
        chk("t1_busy_cycles", 32'(bn), 32'(W));
        chk("t1_sum", 32'(o_sum), 32'h96);
        chk("t1_carry", 32'(o_carry), 32'd0);
        @(negedge i_clk);
        chk("t1_done_pulse", 32'(o_done), 32'd0);
        chk("t1_sum_held", 32'(o_sum), 32'h96);

        do_add(8'hFF, 8'h01, cyc, bn);
        chk("t2a_sum", 32'(o_sum), 32'h00);
        chk("t2a_carry", 32'(o_carry), 32'd1);
        @(negedge i_clk);
        do_add(8'h00, 8'h00, cyc, bn);
        chk("t2b_sum", 32'(o_sum), 32'h00);
        chk("t2b_carry", 32'(o_carry), 32'd0);
        @(negedge i_clk);

        i_start = 1'b1;
        i_a     = 8'h5A;
        i_b     = 8'h3C;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_start = 1'b1;
        i_a     = 8'h11;
        i_b     = 8'h22;
        @(negedge i_clk);
        i_start = 1'b0;
        cyc     = 4;
        while (!o_done && cyc < 30) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("t3_latency", 32'(cyc), 32'(W + 1));
        chk("t3_sum", 32'(o_sum), 32'h96);

        do_add(8'h01, 8'h02, cyc, bn);
        chk("t4_back_to_back", 32'(cyc), 32'(W + 1));
        chk("t4_sum", 32'(o_sum), 32'h03);
        @(negedge i_clk);

        i_start = 1'b1;
        i_a     = 8'hF0;
        i_b     = 8'h0F;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(o_busy), 32'd0);
        chk("t5_sum", 32'(o_sum), 32'd0);
        chk("t5_carry", 32'(o_carry), 32'd0);
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        bn = 0;
        repeat (12) begin
            @(negedge i_clk);
            bn += int'(o_done);
        end
        chk("t5_no_done", 32'(bn), 32'd0);
        do_add(8'h12, 8'h34, cyc, bn);
        chk("t5_after_sum", 32'(o_sum), 32'h46);

`ifdef SERIAL_ADDER_OVF_EN
        @(negedge i_clk);
        do_add(8'h7F, 8'h01, cyc, bn);
        chk("t6a_sum", 32'(o_sum), 32'h80);
        chk("t6a_ovf", 32'(o_overflow), 32'd1);
        do_add(8'hFF, 8'hFF, cyc, bn);
        chk("t6b_sum", 32'(o_sum), 32'hFE);
        chk("t6b_carry", 32'(o_carry), 32'd1);
        chk("t6b_ovf", 32'(o_overflow), 32'd0);
`endif

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i[0]) @(negedge i_clk);
            do_add(ra, rb, cyc, bn);
            chk("rand_result", 32'({o_carry, o_sum}), 32'({1'b0, ra} + {1'b0, rb}));
        end
        @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
